// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register.
// Data only loads when the incoming valid is set, so bubbles do not toggle the data.
module dff_pipe_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/dff_pipe_rv.sv
// Multi-channel register pipeline with valid/ready flow control, bubble collapsing,
// synchronous flush and an occupancy count.
module dff_pipe_rv #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int unsigned BEAT_WIDTH = CHANNELS * DATA_WIDTH;
    localparam int unsigned OCC_WIDTH  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]      v;
    logic [BEAT_WIDTH-1:0] d     [DEPTH];
    logic [DEPTH-1:0]      src_v;
    logic [BEAT_WIDTH-1:0] src_d [DEPTH];
    logic [DEPTH:0]        en;
    logic                  in_fire;
    logic                  out_fire;

    // A stage moves when it is empty or its successor moves; walk from the output side.
    always_comb begin
        en        = '0;
        en[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            en[DEPTH-1-k] = !v[DEPTH-1-k] | en[DEPTH-k];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_v[i] = in_valid;
            assign src_d[i] = in_data;
        end else begin : g_body
            assign src_v[i] = v[i-1];
            assign src_d[i] = d[i-1];
        end

        dff_pipe_stage #(
            .WIDTH (BEAT_WIDTH)
        ) u_stage (
            .clk       (clk),
            .rstn      (rstn),
            .clr       (clr),
            .load      (en[i]),
            .src_valid (src_v[i]),
            .src_data  (src_d[i]),
            .valid     (v[i]),
            .data      (d[i])
        );
    end

    assign in_ready  = en[0] & !clr;
    assign out_valid = v[DEPTH-1] & !clr;
    assign out_data  = d[DEPTH-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occupancy <= '0;
        end else if (clr) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OCC_WIDTH'(1);
                2'b01:   occupancy <= occupancy - OCC_WIDTH'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_pipe_rv.sv
// Directed bench for dff_pipe_rv at DEPTH=4, two 16-bit channels.
module tb_dff_pipe_rv;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    int unsigned tests;
    int unsigned errors;

    dff_pipe_rv #(
        .DATA_WIDTH (16),
        .CHANNELS   (2),
        .DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] beat(input logic [15:0] n);
        return {n, n};
    endfunction

    task automatic test_reset();
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
        tests++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_streaming();
        logic        exp_v;
        logic [31:0] exp_d;
        int          exp_occ;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            in_valid = (c < 8);
            in_data  = beat(16'(c + 1));
            #1;
            exp_v   = (c >= 4) && (c < 12);
            exp_d   = beat(16'(c - 3));
            exp_occ = ((c < 8) ? c : 8) - ((c < 4) ? 0 : (((c < 12) ? c : 12) - 4));
            tests++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_out_valid c=%0d got %b want %b", c, out_valid, exp_v); end
            if (exp_v) begin
                tests++; if (out_data !== exp_d) begin errors++; $display("FAIL stream_out_data c=%0d got %h want %h", c, out_data, exp_d); end
            end
            tests++; if (occupancy !== 3'(exp_occ)) begin errors++; $display("FAIL stream_occupancy c=%0d got %0d want %0d", c, occupancy, exp_occ); end
            if (c < 8) begin
                tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b want 1", c, in_ready); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beat(16'(n + 1));
            #1;
            tests++; if (in_ready !== (c < 4)) begin errors++; $display("FAIL bp_in_ready c=%0d got %b want %b", c, in_ready, (c < 4)); end
            if (c < 4) n++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_full_occupancy got %0d want 4", occupancy); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b1 || out_data !== beat(16'd1)) begin errors++; $display("FAIL bp_drain0 got %b/%h want 1/%h", out_valid, out_data, beat(16'd1)); end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk); #1;
            tests++; if (out_valid !== 1'b1 || out_data !== beat(16'(k + 1))) begin errors++; $display("FAIL bp_drain%0d got %b/%h want 1/%h", k, out_valid, out_data, beat(16'(k + 1))); end
        end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL bp_empty got %b/%0d want 0/0", out_valid, occupancy); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = beat(16'h00AA); #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_push_a got %b want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); in_valid = 1'b1; in_data = beat(16'h00BB); #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_push_b got %b want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bubble_occupancy got %0d want 2", occupancy); end
        tests++; if (out_valid !== 1'b1 || out_data !== beat(16'h00AA)) begin errors++; $display("FAIL bubble_head got %b/%h want 1/%h", out_valid, out_data, beat(16'h00AA)); end
        @(negedge clk); out_ready = 1'b1; #1;
        tests++; if (out_valid !== 1'b1 || out_data !== beat(16'h00AA)) begin errors++; $display("FAIL bubble_out_a got %b/%h want 1/%h", out_valid, out_data, beat(16'h00AA)); end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b1 || out_data !== beat(16'h00BB)) begin errors++; $display("FAIL bubble_out_b got %b/%h want 1/%h", out_valid, out_data, beat(16'h00BB)); end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL bubble_empty got %b/%0d want 0/0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = beat(16'(16'h00F1 + c));
        end
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = beat(16'h00F4); clr = 1'b1; #1;
        tests++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        tests++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occupancy got %0d want 3", occupancy); end
        @(negedge clk); clr = 1'b0; in_valid = 1'b1; in_data = beat(16'h00F5); out_ready = 1'b1; #1;
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got %0d/%b want 0/0", occupancy, out_valid); end
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_back got %b want 1", in_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_latency c=%0d got %b want 0", c, out_valid); end
        end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b1 || out_data !== beat(16'h00F5)) begin errors++; $display("FAIL flush_new_beat got %b/%h want 1/%h", out_valid, out_data, beat(16'h00F5)); end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = beat(16'h0011);
        @(negedge clk); in_valid = 1'b1; in_data = beat(16'h0022);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL areset_pre got %b/%0d want 1/2", out_valid, occupancy); end
        #2 rstn = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b want 0", out_valid); end
        tests++; if (occupancy !== 3'd0) begin errors++; $display("FAIL areset_occupancy got %0d want 0", occupancy); end
        tests++; if (out_data !== 32'h0) begin errors++; $display("FAIL areset_out_data got %h want 00000000", out_data); end
        @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL areset_stale c=%0d got %b/%0d want 0/0", c, out_valid, occupancy); end
            @(negedge clk);
        end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
